adc_sar_ctrl: RTL

Parametrised synchronous SAR ADC controller. It drives the sampling switch and the capacitive DAC trial code of the analog SAR core, and resolves one bit per step from the comparator. It publishes the result on a parallel bus and in a serial shift register that can be daisy-chained (`dati`/`dato`). The block is the digital half of the ADC macro and sits between the analog core and the chip-level control logic.

---
 rtl/adc_sar_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/adc_sar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_sar_ctrl
// Description : Synchronous successive-approximation ADC controller. Drives
//               the sampling switch and cap-DAC trial code, resolves one bit
//               per step from the comparator, and publishes the result on a
//               parallel bus and a daisy-chainable serial shift register.
//               Optional feature macro: ADC_CONT_EN (back-to-back conversions
//               directly from DONE while conv_start is held high).
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sar_ctrl #(
  parameter int NBITS      = 8,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             conv_start,
  input  logic             comp_in,
  input  logic             load,
  input  logic             dati,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic             conv_finish,
  output logic [NBITS-1:0] result,
  output logic             dato
);

  // One counter serves both the sampling window and the per-bit settle time.
  localparam int MAX_CYC = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(NBITS);

  localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NBITS-1:0]   code_q, code_d;
  logic [NBITS-1:0]   result_q, result_d;
  logic [NBITS-1:0]   sr_q, sr_d;
  logic [NBITS-1:0]   trial_bit;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      result_q <= result_d;
      sr_q     <= sr_d;
    end
  end

  // Next-state logic and Moore outputs; every output is a function of registers only.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    code_d      = code_q;
    result_d    = result_q;
    sr_d        = sr_q;
    trial_bit   = NBITS'(1) << idx_q;
    sample      = 1'b0;
    busy        = 1'b1;
    conv_finish = 1'b0;
    dac_code    = code_q;

    // Serial shift runs in any state; the DONE parallel load below overrides it.
    if (load) begin
      sr_d = {sr_q[NBITS-2:0], dati};
    end

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (conv_start) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          code_d  = '0;
        end
      end

      S_SAMPLE: begin
        sample = 1'b1;
        if (cnt_q == SAMP_LAST) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
          idx_d   = IDX_MSB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CONVERT: begin
        dac_code = code_q | trial_bit;
        if (cnt_q == SETTLE_LAST) begin
          // Keep the trial bit only when the input is at or above the DAC level.
          code_d[idx_q] = comp_in;
          cnt_d         = '0;
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        conv_finish = 1'b1;
        result_d    = code_q;
        sr_d        = code_q;
`ifdef ADC_CONT_EN
        if (conv_start) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          code_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result = result_q;
  assign dato   = sr_q[NBITS-1];

endmodule
`default_nettype wire
